// File: rtl/fetch_unit.sv
// Fetch stage: holds the fetch PC, issues single-outstanding word requests and buffers returns for decode.
// Optional misaligned-redirect trap: define FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] NextPC,
    input  logic        Redirect,
    output logic        IReq,
    output logic [31:0] IAddr,
    input  logic        IGnt,
    input  logic        IRValid,
    input  logic [31:0] IRData,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PC4,
    output logic        ExcAdEL
);
    localparam int          PW    = $clog2(BUF_DEPTH);
    localparam logic [PW:0] DEPTH = (PW+1)'(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc, fetch_pc_nxt, req_addr, redir_pc;
    logic          drop, drop_nxt, halt, halt_nxt;
    logic [31:0]   buf_pc    [BUF_DEPTH];
    logic [31:0]   buf_instr [BUF_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count, count_nxt;
    logic          pop, push, resp, misalign;

    assign redir_pc = {NextPC[31:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign = Redirect & (NextPC[1:0] != 2'b00);
`else
    logic unused_lo;
    assign misalign  = 1'b0;
    assign unused_lo = ^NextPC[1:0];
`endif

    assign InstrValid = (count != '0);
    assign pop        = InstrValid & InstrReady;
    assign resp       = (state == WAIT) & IRValid;
    // A response arriving with a redirect, or owed to a pre-redirect request, is discarded.
    assign push       = resp & ~drop & ~Redirect;

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        drop_nxt     = drop;
        halt_nxt     = halt;
        if (Redirect)
            count_nxt = misalign ? (PW+1)'(1) : '0;
        else
            count_nxt = count + (PW+1)'(push) - (PW+1)'(pop);

        case (state)
            IDLE: ;
            REQ: if (IGnt) begin
                state_nxt = WAIT;
                if (!drop) fetch_pc_nxt = req_addr + 32'd4;
            end
            WAIT: if (IRValid) begin
                state_nxt = IDLE;
                drop_nxt  = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase

        if (Redirect) begin
            fetch_pc_nxt = redir_pc;
            halt_nxt     = misalign;
            if ((state == REQ) || (state == WAIT && !IRValid)) drop_nxt = 1'b1;
        end

        // Issue only when the response is guaranteed a free slot.
        if (state_nxt == IDLE && !halt_nxt && count_nxt < DEPTH) state_nxt = REQ;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            drop     <= 1'b0;
            halt     <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_pc[i]    <= RESET_PC;
                buf_instr[i] <= '0;
            end
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            drop     <= drop_nxt;
            halt     <= halt_nxt;
            count    <= count_nxt;
            if (state != REQ && state_nxt == REQ) req_addr <= fetch_pc_nxt;
            if (Redirect) begin
                rd_ptr <= '0;
                wr_ptr <= misalign ? PW'(1) : '0;
                if (misalign) begin
                    buf_pc[0]    <= NextPC;
                    buf_instr[0] <= '0;
                end
            end else begin
                if (push) begin
                    buf_pc[wr_ptr]    <= req_addr;
                    buf_instr[wr_ptr] <= IRData;
                    wr_ptr            <= wr_ptr + PW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic buf_exc [BUF_DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) buf_exc[i] <= 1'b0;
        end else if (Redirect) begin
            if (misalign) buf_exc[0] <= 1'b1;
        end else if (push) begin
            buf_exc[wr_ptr] <= 1'b0;
        end
    end

    assign ExcAdEL = InstrValid & buf_exc[rd_ptr];
`else
    assign ExcAdEL = 1'b0;
`endif

    assign IReq  = (state == REQ);
    assign IAddr = req_addr;
    assign Instr = buf_instr[rd_ptr];
    assign PC    = buf_pc[rd_ptr];
    assign PC4   = PC + 32'd4;
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and instruction-fetch stage; consumes the redirect address computed by the next-PC logic.
- Holds the fetch PC and issues word requests to instruction memory over a req/gnt/rvalid protocol.
- Buffers returned instructions with their PC, and presents them to decode over a valid/ready handshake.
- Flushes on a control-transfer redirect.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- BUF_DEPTH, 2, instruction buffer entries (power of 2, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- NextPC  in  32  target address from next-PC logic; sampled only when Redirect=1.
- Redirect  in  1  taken jump/branch/jr; flush and refetch from NextPC.
- IReq  out  1  instruction memory request.
- IAddr  out  32  request word address.
- IGnt  in  1  memory accepts request this cycle.
- IRValid  in  1  read data valid; exactly one per granted request, in order, ≥1 cycle after grant.
- IRData  in  32  read data.
- InstrValid  out  1  buffer head valid.
- InstrReady  in  1  decode accepts head.
- Instr  out  32  head instruction.
- PC  out  32  head instruction address.
- PC4  out  32  PC+4 (mod 2^32).
- ExcAdEL  out  1  see Optional Feature; tied 0 when the feature is disabled.

Behaviour:
- Reset values: IReq=0, IAddr=RESET_PC, InstrValid=0, Instr=0, PC=RESET_PC, PC4=RESET_PC+4, ExcAdEL=0, buffer empty, outstanding=0, drop=0.
- Reset is asynchronous; assertion mid-transfer abandons everything. The memory side must also be reset.
- FSM states:
  - IDLE: may issue when count+outstanding < BUF_DEPTH.
  - REQ: IReq=1, IAddr=FetchPC.
  - WAIT: one request outstanding.
- FSM transitions:
  - First rising edge after reset release: IDLE→REQ.
  - REQ & IGnt: →WAIT; FetchPC += 4, wrapping 32'hFFFF_FFFC→0.
  - WAIT & IRValid: →REQ if space remains after the write, else →IDLE.
  - IDLE→REQ when space becomes available.
- Maximum of one outstanding request.
- Protocol: once IReq=1, IAddr and IReq are held stable until IGnt. A request is never withdrawn.
- IRValid (not dropped): write {FetchPC of that request, IRData} into the buffer. InstrValid=1 from the following cycle; latency is 1 cycle from IRValid.
- Head pops on InstrValid & InstrReady. Simultaneous pop and push is allowed at full.
- Redirect (priority over everything else):
  - Buffer flushed at the edge; InstrValid=0 next cycle.
  - A pop in the same cycle still counts as consumed.
  - FetchPC <= {NextPC[31:2],2'b00}.
  - In WAIT: drop=1; the matching IRValid is discarded, then →REQ at NextPC.
  - In REQ without IGnt: request held until granted, response dropped, then re-request at NextPC.
  - In REQ with IGnt same cycle: →WAIT with drop=1.
  - IRValid in the same cycle as Redirect: data discarded.
- Redirect repeated while drop=1: drop stays 1 and the latest NextPC wins.
- Buffer full: no request issued. The in-flight response always has a reserved slot.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - A Redirect with NextPC[1:0]≠0 flushes as normal but issues no memory request.
  - Pushes one entry {PC=NextPC unmodified, Instr=32'h0} with ExcAdEL=1 on that entry.
  - Fetch then stalls in IDLE until the next Redirect.
- Undefined: low two bits are silently cleared and ExcAdEL is tied 0.

Test Plan:
- Reset release, IGnt=1, IRValid 1 cycle after grant, InstrReady=1 → IAddr sequence 3000, 3004, 3008; Instr/PC pairs delivered in order; PC4=PC+4.
- InstrReady=0 for 10 cycles → exactly 2 entries buffered, IReq stays 0 while full. After release, fetch resumes at 3008 with no loss or duplication.
- Redirect NextPC=0x0000_3100 while in WAIT for 3010 → the 3010 response is dropped; next IAddr=3100; first delivered PC=3100.
- IReq held with IGnt=0 for 3 cycles, Redirect in cycle 1 → IAddr stays 3004 until granted, its data is dropped, next request is 3100.
- Redirect with simultaneous pop and IRValid → popped instruction counted; incoming data discarded; InstrValid=0 next cycle.
- FETCH_ALIGN_CHECK_EN, NextPC=0x0000_3102 → one entry with ExcAdEL=1, PC=3102, Instr=0; no IReq until the next Redirect.
